// File: rtl/jtdd_arb_pkg.sv
// Shared definitions for the main-CPU/MCU shared RAM arbiter.
//   arb_state_e : arbiter states (IDLE, HALTREQ, MCU, RELEASE)
//   HALT_CNT_W  : width of the halt-delay cen counter (HALT_DLY range 1..15)
package jtdd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HALTREQ,
    MCU,
    RELEASE
  } arb_state_e;

  localparam int unsigned HALT_CNT_W = 4;

endpackage

// File: rtl/jtdd_arb_flag.sv
// Set/acknowledge interrupt flag. Set has priority over ack in the same clk.
//   clk, rst : clock, asynchronous active-high reset
//   set      : raise the flag
//   ack      : clear the flag
//   flag     : flag level
module jtdd_arb_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic ack,
  output logic flag
);

  logic flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      flag_q <= 1'b0;
    else if (set) flag_q <= 1'b1;
    else if (ack) flag_q <= 1'b0;
  end

  assign flag = flag_q;

endmodule

// File: rtl/jtframe_ram.sv
// Single-port RAM, 2^AW words of DW bits.
//   clk  : write clock
//   data : write data
//   addr : read/write address
//   we   : write enable, sampled on clk
//   q    : read data for addr (combinational; callers register it)
module jtframe_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
  end

  assign q = mem[addr];

endmodule

// File: rtl/jtdd_shared_arb.sv
// Main-CPU/MCU shared RAM arbiter plus main<->MCU NMI/IRQ handshake.
// The main CPU owns the RAM by default; an MCU bus request halts the main CPU,
// grants the MCU after HALT_DLY cen pulses and returns the RAM afterwards.
// Ports:
//   clk, rst, cen                  : clock, async active-high reset, CPU clock enable
//   main_cs/wrn/addr/dout, main_din: main CPU RAM port
//   main_halt                      : halt request to main CPU
//   mcu_busreq, mcu_gnt            : MCU bus request / grant
//   mcu_addr/we/dout, mcu_din      : MCU RAM port
//   nmi_set, mcu_nmi, mcu_nmi_ack  : main -> MCU NMI
//   irq_set, main_irq, main_irq_ack: MCU -> main IRQ
// Build option JTDD_ARB_TIMEOUT_EN: limits an MCU grant to TIMEOUT cen pulses
// and blocks new grants until mcu_busreq has been seen low.
module jtdd_shared_arb
  import jtdd_arb_pkg::*;
#(
  parameter int unsigned AW       = 9,
  parameter int unsigned HALT_DLY = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          main_cs,
  input  logic          main_wrn,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic [7:0]    main_din,
  output logic          main_halt,
  input  logic          mcu_busreq,
  output logic          mcu_gnt,
  input  logic [AW-1:0] mcu_addr,
  input  logic          mcu_we,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  input  logic          nmi_set,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_ack,
  input  logic          irq_set,
  output logic          main_irq,
  input  logic          main_irq_ack
);

  localparam logic [HALT_CNT_W-1:0] HALT_LAST = HALT_CNT_W'(HALT_DLY - 1);

  arb_state_e            state_q, state_d;
  logic [HALT_CNT_W-1:0] halt_cnt_q, halt_cnt_d;
  logic                  timeout_hit;
  logic                  grant_ok;
  logic [7:0]            main_din_q, mcu_din_q;

`ifdef JTDD_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            blk_q, blk_d;

  assign timeout_hit = (state_q == MCU) && cen && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign grant_ok    = !blk_q;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == MCU) to_cnt_d = cen ? to_cnt_q + 1'b1 : to_cnt_q;
    blk_d = blk_q;
    if (timeout_hit)      blk_d = 1'b1;
    else if (!mcu_busreq) blk_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      blk_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      blk_q    <= blk_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign grant_ok    = 1'b1;

  // TIMEOUT is unused without the counter; kept so both builds share one parameter list.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d    = state_q;
    halt_cnt_d = halt_cnt_q;
    case (state_q)
      IDLE: begin
        halt_cnt_d = '0;
        if (mcu_busreq && !main_cs && grant_ok) state_d = HALTREQ;
      end
      HALTREQ: begin
        if (!mcu_busreq) begin
          state_d = RELEASE;
        end else if (cen) begin
          if (halt_cnt_q == HALT_LAST) state_d = MCU;
          else                         halt_cnt_d = halt_cnt_q + 1'b1;
        end
      end
      MCU: begin
        if (!mcu_busreq || timeout_hit) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      halt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      halt_cnt_q <= halt_cnt_d;
    end
  end

  assign main_halt = (state_q != IDLE);
  assign mcu_gnt   = (state_q == MCU);

  // RAM port mux: only the MCU state hands the port to the MCU. Main writes
  // additionally need IDLE so nothing lands while a halt is pending or releasing.
  logic          sel_mcu;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data, ram_q;
  logic          ram_we;

  assign sel_mcu  = mcu_gnt;
  assign ram_addr = sel_mcu ? mcu_addr : main_addr;
  assign ram_data = sel_mcu ? mcu_dout : main_dout;
  assign ram_we   = sel_mcu ? (mcu_we & mcu_gnt)
                            : (main_cs & ~main_wrn & cen & (state_q == IDLE));

  jtframe_ram #(.DW(8), .AW(AW)) u_ram (
    .clk  (clk),
    .data (ram_data),
    .addr (ram_addr),
    .we   (ram_we),
    .q    (ram_q)
  );

  // Each side keeps its last read value while the other side owns the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_din_q <= '0;
      mcu_din_q  <= '0;
    end else begin
      if (cen && !sel_mcu) main_din_q <= ram_q;
      if (sel_mcu)         mcu_din_q  <= ram_q;
    end
  end

  assign main_din = main_din_q;
  assign mcu_din  = mcu_din_q;

  jtdd_arb_flag u_nmi (
    .clk  (clk),
    .rst  (rst),
    .set  (nmi_set),
    .ack  (mcu_nmi_ack),
    .flag (mcu_nmi)
  );

  jtdd_arb_flag u_irq (
    .clk  (clk),
    .rst  (rst),
    .set  (irq_set),
    .ack  (main_irq_ack),
    .flag (main_irq)
  );

endmodule

// File: tb/tb_jtdd_shared_arb.sv
module tb_jtdd_shared_arb;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic       main_cs, main_wrn;
  logic [8:0] main_addr, mcu_addr;
  logic [7:0] main_dout, mcu_dout, main_din, mcu_din;
  logic       main_halt, mcu_busreq, mcu_gnt, mcu_we;
  logic       nmi_set, mcu_nmi, mcu_nmi_ack;
  logic       irq_set, main_irq, main_irq_ack;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  jtdd_shared_arb #(.AW(9), .HALT_DLY(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr),
    .main_dout(main_dout), .main_din(main_din), .main_halt(main_halt),
    .mcu_busreq(mcu_busreq), .mcu_gnt(mcu_gnt), .mcu_addr(mcu_addr),
    .mcu_we(mcu_we), .mcu_dout(mcu_dout), .mcu_din(mcu_din),
    .nmi_set(nmi_set), .mcu_nmi(mcu_nmi), .mcu_nmi_ack(mcu_nmi_ack),
    .irq_set(irq_set), .main_irq(main_irq), .main_irq_ack(main_irq_ack)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = '0; main_dout = '0;
    mcu_busreq = 1'b0; mcu_addr = '0; mcu_we = 1'b0; mcu_dout = '0;
    nmi_set = 1'b0; mcu_nmi_ack = 1'b0; irq_set = 1'b0; main_irq_ack = 1'b0;
    tick(); tick();
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL rst_halt: got %b want 0", main_halt); else pass_cnt++;
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", mcu_gnt); else pass_cnt++;
    total_cnt++; if (mcu_nmi !== 1'b0) $display("FAIL rst_nmi: got %b want 0", mcu_nmi); else pass_cnt++;
    total_cnt++; if (main_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", main_irq); else pass_cnt++;
    total_cnt++; if (main_din !== 8'h00) $display("FAIL rst_main_din: got %h want 00", main_din); else pass_cnt++;
    total_cnt++; if (mcu_din !== 8'h00) $display("FAIL rst_mcu_din: got %h want 00", mcu_din); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_main_rw();
    // write 11 to 000 and 5A to 010, then read 010
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 9'h000; main_dout = 8'h11;
    tick();
    main_addr = 9'h010; main_dout = 8'h5A;
    tick();
    main_wrn = 1'b1;
    tick();
    total_cnt++; if (main_din !== 8'h5A) $display("FAIL main_read: got %h want 5a", main_din); else pass_cnt++;
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL main_rw_gnt: got %b want 0", mcu_gnt); else pass_cnt++;
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL main_rw_halt: got %b want 0", main_halt); else pass_cnt++;
    main_cs = 1'b0;
  endtask

  task automatic test_mcu_grant();
    mcu_busreq = 1'b1;
    tick();
    total_cnt++; if (main_halt !== 1'b1) $display("FAIL haltreq_halt: got %b want 1", main_halt); else pass_cnt++;
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL haltreq_gnt0: got %b want 0", mcu_gnt); else pass_cnt++;
    tick();
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL haltreq_gnt1: got %b want 0", mcu_gnt); else pass_cnt++;
    tick();
    total_cnt++; if (mcu_gnt !== 1'b1) $display("FAIL grant: got %b want 1", mcu_gnt); else pass_cnt++;
    // MCU writes C3 to 1FF and reads it back
    mcu_addr = 9'h1FF; mcu_dout = 8'hC3; mcu_we = 1'b1;
    tick();
    mcu_we = 1'b0;
    tick();
    total_cnt++; if (mcu_din !== 8'hC3) $display("FAIL mcu_read: got %h want c3", mcu_din); else pass_cnt++;
    // main write to 000 while MCU owns the RAM must be dropped
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 9'h000; main_dout = 8'hFF;
    mcu_addr = 9'h000;
    tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    tick();
    total_cnt++; if (mcu_din !== 8'h11) $display("FAIL dropped_write: got %h want 11", mcu_din); else pass_cnt++;
    total_cnt++; if (main_din !== 8'h5A) $display("FAIL nonowner_hold: got %h want 5a", main_din); else pass_cnt++;
    mcu_busreq = 1'b0;
    tick();
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL release_gnt: got %b want 0", mcu_gnt); else pass_cnt++;
    total_cnt++; if (main_halt !== 1'b1) $display("FAIL release_halt: got %b want 1", main_halt); else pass_cnt++;
    tick();
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL idle_halt: got %b want 0", main_halt); else pass_cnt++;
    main_cs = 1'b1; main_wrn = 1'b1; main_addr = 9'h1FF;
    tick();
    total_cnt++; if (main_din !== 8'hC3) $display("FAIL main_read_1ff: got %h want c3", main_din); else pass_cnt++;
    main_addr = 9'h000;
    tick();
    total_cnt++; if (main_din !== 8'h11) $display("FAIL main_read_000: got %h want 11", main_din); else pass_cnt++;
    main_cs = 1'b0;
  endtask

  task automatic test_flags();
    nmi_set = 1'b1; mcu_nmi_ack = 1'b1;
    tick();
    total_cnt++; if (mcu_nmi !== 1'b1) $display("FAIL nmi_set_wins: got %b want 1", mcu_nmi); else pass_cnt++;
    nmi_set = 1'b0;
    tick();
    total_cnt++; if (mcu_nmi !== 1'b0) $display("FAIL nmi_ack: got %b want 0", mcu_nmi); else pass_cnt++;
    mcu_nmi_ack = 1'b0; nmi_set = 1'b1;
    tick(); tick();
    nmi_set = 1'b0; mcu_nmi_ack = 1'b1;
    tick();
    total_cnt++; if (mcu_nmi !== 1'b0) $display("FAIL nmi_double_set: got %b want 0", mcu_nmi); else pass_cnt++;
    mcu_nmi_ack = 1'b0;
    irq_set = 1'b1; main_irq_ack = 1'b1;
    tick();
    total_cnt++; if (main_irq !== 1'b1) $display("FAIL irq_set_wins: got %b want 1", main_irq); else pass_cnt++;
    irq_set = 1'b0;
    tick();
    total_cnt++; if (main_irq !== 1'b0) $display("FAIL irq_ack: got %b want 0", main_irq); else pass_cnt++;
    main_irq_ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    mcu_busreq = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (mcu_gnt !== 1'b1) $display("FAIL pre_rst_gnt: got %b want 1", mcu_gnt); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL async_rst_gnt: got %b want 0", mcu_gnt); else pass_cnt++;
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL async_rst_halt: got %b want 0", main_halt); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++; if (main_halt !== 1'b1) $display("FAIL restart_halt: got %b want 1", main_halt); else pass_cnt++;
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL restart_gnt: got %b want 0", mcu_gnt); else pass_cnt++;
    mcu_busreq = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    mcu_busreq = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (mcu_gnt !== 1'b1) $display("FAIL to_grant: got %b want 1", mcu_gnt); else pass_cnt++;
    for (int i = 0; i < 7; i++) tick();
`ifdef JTDD_ARB_TIMEOUT_EN
    total_cnt++; if (mcu_gnt !== 1'b1) $display("FAIL to_gnt_7: got %b want 1", mcu_gnt); else pass_cnt++;
    tick();
    total_cnt++; if (mcu_gnt !== 1'b0) $display("FAIL to_gnt_8: got %b want 0", mcu_gnt); else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL to_blocked_halt: got %b want 0", main_halt); else pass_cnt++;
    mcu_busreq = 1'b0;
    tick();
    mcu_busreq = 1'b1;
    tick();
    total_cnt++; if (main_halt !== 1'b1) $display("FAIL to_regrant_halt: got %b want 1", main_halt); else pass_cnt++;
`else
    for (int i = 0; i < 13; i++) tick();
    total_cnt++; if (mcu_gnt !== 1'b1) $display("FAIL held_grant: got %b want 1", mcu_gnt); else pass_cnt++;
`endif
    mcu_busreq = 1'b0;
    tick(); tick();
    total_cnt++; if (main_halt !== 1'b0) $display("FAIL to_final_idle: got %b want 0", main_halt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_main_rw();
    test_mcu_grant();
    test_flags();
    test_reset_mid_grant();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
